fetch_block: RTL and testbench

Instruction fetch stage of the pipelined Thumb CPU. It owns the fetch program counter, issues 16-bit instruction reads to instruction memory over a request/grant/response handshake, and buffers returned halfwords in a small prefetch FIFO. It presents one instruction per cycle to the decode stage through a registered fetch/decode boundary. It honours decode's stall signal and redirects on a pipeline flush, discarding stale in-flight responses.

---
 rtl/general_defs_pkg.sv | 24 ++
 rtl/fetch_buffer.sv | 86 ++++++++
 rtl/fetch_block.sv | 143 ++++++++++++++
 tb/tb_fetch_block.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/general_defs_pkg.sv
// -----------------------------------------------------------------------------
// general_defs_pkg
// Shared CPU-wide type definitions plus the fetch-stage additions:
//   WORD, instruction         - datapath word and Thumb halfword types
//   stall_pipeline_sig        - decode-to-fetch stall request
//   flush_pipeline_sig        - pipeline redirect request
//   FETCH_FIFO_DEPTH          - default prefetch FIFO depth / fetch credit
//   fetch_entry               - one buffered fetch: address plus halfword
// -----------------------------------------------------------------------------
package general_defs_pkg;

   typedef logic [31:0] WORD;
   typedef logic [15:0] instruction;
   typedef logic        stall_pipeline_sig;
   typedef logic        flush_pipeline_sig;

   localparam int FETCH_FIFO_DEPTH = 2;

   typedef struct packed {
      WORD        addr;
      instruction instr;
   } fetch_entry;

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Synchronous prefetch FIFO of fetch_entry records.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset
//   push_i          write push_data_i at the tail (ignored when full)
//   pop_i           drop the head entry (ignored when empty)
//   clear_i         empty the FIFO; overrides push and pop
//   push_data_i     entry to write
//   full_o, empty_o occupancy flags
//   count_o         number of valid entries
//   head_o          oldest entry, valid whenever empty_o is low
// -----------------------------------------------------------------------------
module fetch_buffer
   import general_defs_pkg::*;
#(
   parameter int DEPTH = FETCH_FIFO_DEPTH
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       clear_i,
   input  fetch_entry                 push_data_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output fetch_entry                 head_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o && !clear_i;
   assign do_pop  = pop_i && !empty_o && !clear_i;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and count define which entries are meaningful.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/fetch_block.sv
// -----------------------------------------------------------------------------
// fetch_block
// Instruction fetch stage: owns the fetch PC, issues halfword reads over a
// req/gnt/rvalid handshake, buffers responses in fetch_buffer and presents one
// instruction per cycle through a registered fetch/decode boundary.
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   stall_i                 decode stall; output register holds
//   flush_i                 redirect to branch_target_i, discard in-flight work
//   branch_target_i         redirect address (bit 0 ignored)
//   imem_req_o/imem_addr_o  fetch request and halfword address (= fetch PC)
//   imem_gnt_i              request accepted this cycle
//   imem_rvalid_i/rdata_i   in-order response
//   instruction_o           instruction to decode
//   program_counter_o       instruction address + 4
//   is_valid_o              output register holds a live instruction
// -----------------------------------------------------------------------------
module fetch_block
   import general_defs_pkg::*;
#(
   parameter WORD RESET_PC   = 32'h0000_0000,
   parameter int  FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  stall_pipeline_sig stall_i,
   input  flush_pipeline_sig flush_i,
   input  WORD               branch_target_i,
   output logic              imem_req_o,
   output WORD               imem_addr_o,
   input  logic              imem_gnt_i,
   input  logic              imem_rvalid_i,
   input  logic [15:0]       imem_rdata_i,
   output instruction        instruction_o,
   output WORD               program_counter_o,
   output logic              is_valid_o
);

   localparam int  CW       = $clog2(FIFO_DEPTH + 1);
   localparam WORD START_PC = {RESET_PC[31:1], 1'b0};

   WORD           pc_q, pc_d;             // next address to request
   WORD           resp_pc_q, resp_pc_d;   // address of the next live response
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_q, drop_d;
   instruction    instr_q, instr_d;
   WORD           pc_out_q, pc_out_d;
   logic          valid_q, valid_d;

   logic          granted, resp_live, push, pop;
   logic [CW:0]   credit_used;
   WORD           target_pc;
   fetch_entry    push_entry, head;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          unused_sink;

   // Responses owed to pre-flush requests arrive first (in order) and are swallowed.
   assign resp_live   = imem_rvalid_i && (drop_q == '0);
   assign push        = resp_live && !flush_i;
   assign pop         = !stall_i && !flush_i && !fifo_empty;
   assign target_pc   = {branch_target_i[31:1], 1'b0};
   assign push_entry  = '{addr: resp_pc_q, instr: imem_rdata_i};

   // A slot popped this cycle is free again, so it is not counted against credit.
   assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count} - (CW+1)'(pop);
   assign imem_req_o  = !reset_i && !flush_i && (credit_used < (CW+1)'(FIFO_DEPTH));
   assign imem_addr_o = pc_q;
   assign granted     = imem_req_o && imem_gnt_i;

   assign instruction_o     = instr_q;
   assign program_counter_o = pc_out_q;
   assign is_valid_o        = valid_q;

   // fifo_full only serves observation of the overflow invariant.
   assign unused_sink = ^{branch_target_i[0], fifo_full};

   fetch_buffer #(
      .DEPTH (FIFO_DEPTH)
   ) u_buffer (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .push_i      (push),
      .pop_i       (pop),
      .clear_i     (flush_i),
      .push_data_i (push_entry),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count),
      .head_o      (head)
   );

   always_comb begin
      pc_d          = pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      instr_d       = instr_q;
      pc_out_d      = pc_out_q;
      valid_d       = valid_q;
      if (flush_i) begin
         pc_d          = target_pc;
         resp_pc_d     = target_pc;
         outstanding_d = '0;
         // Every response still owed becomes stale; one is consumed right now if rvalid is up.
         drop_d        = CW'({1'b0, drop_q} + {1'b0, outstanding_q} - (CW+1)'(imem_rvalid_i));
         valid_d       = 1'b0;
      end else begin
         if (granted) pc_d = pc_q + 32'd2;
         if (push)    resp_pc_d = resp_pc_q + 32'd2;
         outstanding_d = outstanding_q + CW'(granted) - CW'(resp_live);
         if (imem_rvalid_i && (drop_q != '0)) drop_d = drop_q - CW'(1);
         if (!stall_i) begin
            valid_d = !fifo_empty;
            if (!fifo_empty) begin
               instr_d  = head.instr;
               pc_out_d = head.addr + 32'd4;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pc_q          <= START_PC;
         resp_pc_q     <= START_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
         instr_q       <= '0;
         pc_out_q      <= '0;
         valid_q       <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         instr_q       <= instr_d;
         pc_out_q      <= pc_out_d;
         valid_q       <= valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_block.sv
// -----------------------------------------------------------------------------
// tb_fetch_block
// Drives fetch_block against an in-order instruction memory model with
// configurable latency and grant probability. Each granted fetch pushes the
// expected address onto a scoreboard queue; each new decode-side instruction
// pops and compares it. Directed phases cover reset, stall, flushes and an
// asynchronous mid-stream reset; a random phase mixes latency, grant gaps,
// stalls and flushes.
// -----------------------------------------------------------------------------
module tb_fetch_block;
   import general_defs_pkg::*;

   localparam WORD RESET_PC   = 32'h0000_0100;
   localparam int  FIFO_DEPTH = 2;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       stall_i, flush_i;
   WORD        branch_target_i;
   logic       imem_req_o;
   WORD        imem_addr_o;
   logic       imem_gnt_i, imem_rvalid_i;
   logic [15:0] imem_rdata_i;
   instruction instruction_o;
   WORD        program_counter_o;
   logic       is_valid_o;

   fetch_block #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk_i             (clk_i),
      .reset_i           (reset_i),
      .stall_i           (stall_i),
      .flush_i           (flush_i),
      .branch_target_i   (branch_target_i),
      .imem_req_o        (imem_req_o),
      .imem_addr_o       (imem_addr_o),
      .imem_gnt_i        (imem_gnt_i),
      .imem_rvalid_i     (imem_rvalid_i),
      .imem_rdata_i      (imem_rdata_i),
      .instruction_o     (instruction_o),
      .program_counter_o (program_counter_o),
      .is_valid_o        (is_valid_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      WORD addr;
      int  due;
   } req_t;

   req_t       pend[$];    // granted requests awaiting a response, in order
   WORD        exp_q[$];   // scoreboard: addresses decode should still see
   int         cyc = 0;
   int         lat_min, lat_max, gnt_pct;
   int         n_checks = 0;
   int         n_pass = 0;
   logic       last_req, last_gnt;
   WORD        last_addr;
   WORD        model_fetch_pc;
   logic       model_valid;
   WORD        model_pc;
   instruction model_instr;

   function automatic instruction mem_data(input WORD a);
      return a[16:1] ^ 16'hC35A;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, want, $time);
   endtask

   // One clock cycle, entered and left at the falling edge.
   task automatic step(input logic stall, input logic flush, input WORD target);
      logic rv, gr;
      req_t r;
      stall_i         = stall;
      flush_i         = flush;
      branch_target_i = target;
      rv              = (pend.size() > 0) && (pend[0].due <= cyc);
      imem_rvalid_i   = rv;
      imem_rdata_i    = '0;
      if (rv) imem_rdata_i = mem_data(pend[0].addr);
      imem_gnt_i      = 1'b0;
      #1;
      gr         = imem_req_o && ($urandom_range(99) < 32'(gnt_pct));
      imem_gnt_i = gr;
      last_req   = imem_req_o;
      last_addr  = imem_addr_o;
      last_gnt   = gr;
      if (flush) check("req_during_flush", 32'(imem_req_o), 32'd0);
      if (imem_req_o) check("fetch_addr", imem_addr_o, model_fetch_pc);
      if (rv && (dut.drop_q == '0) && !flush) check("fifo_no_overflow", 32'(dut.fifo_full), 32'd0);
      @(posedge clk_i);
      if (rv) void'(pend.pop_front());
      if (gr) begin
         r.addr = model_fetch_pc;
         r.due  = cyc + 1 + int'($urandom_range(lat_max, lat_min));
         pend.push_back(r);
         exp_q.push_back(model_fetch_pc);
      end
      cyc++;
      if (flush) begin
         exp_q.delete();
         model_fetch_pc = target & ~32'd1;
      end else if (gr) begin
         model_fetch_pc = model_fetch_pc + 32'd2;
      end
      @(negedge clk_i);
      if (flush) begin
         model_valid = 1'b0;
         check("flush_valid", 32'(is_valid_o), 32'd0);
      end else if (stall) begin
         check("hold_valid", 32'(is_valid_o), 32'(model_valid));
         check("hold_pc", program_counter_o, model_pc);
         check("hold_instr", 32'(instruction_o), 32'(model_instr));
      end else if (is_valid_o) begin
         check("instr_expected", 32'(is_valid_o), 32'(exp_q.size() > 0));
         if (exp_q.size() > 0) begin
            r.addr      = exp_q.pop_front();
            model_valid = 1'b1;
            model_pc    = r.addr + 32'd4;
            model_instr = mem_data(r.addr);
            check("stream_pc", program_counter_o, model_pc);
            check("stream_instr", 32'(instruction_o), 32'(model_instr));
         end
      end else begin
         model_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      reset_i         = 1'b1;
      stall_i         = 1'b0;
      flush_i         = 1'b0;
      branch_target_i = '0;
      imem_gnt_i      = 1'b0;
      imem_rvalid_i   = 1'b0;
      imem_rdata_i    = '0;
      pend.delete();
      exp_q.delete();
      model_valid     = 1'b0;
      model_pc        = '0;
      model_instr     = '0;
      model_fetch_pc  = RESET_PC & ~32'd1;
      repeat (2) @(negedge clk_i);
      check("rst_req", 32'(imem_req_o), 32'd0);
      check("rst_valid", 32'(is_valid_o), 32'd0);
      check("rst_pc_out", program_counter_o, 32'd0);
      check("rst_instr", 32'(instruction_o), 32'd0);
      reset_i = 1'b0;
   endtask

   // Zero-wait start-up: sequential requests, first valid three cycles after release.
   task automatic boot_check();
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b0, '0);
         check("boot_req", 32'(last_req), 32'd1);
         check("boot_addr", last_addr, (RESET_PC & ~32'd1) + 32'(2 * k));
         if (k < 2) begin
            check("boot_valid_low", 32'(is_valid_o), 32'd0);
         end else begin
            check("boot_valid", 32'(is_valid_o), 32'd1);
            check("boot_pc", program_counter_o, RESET_PC + 32'(4 + 2 * (k - 2)));
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int   n_gr, exp_drop;
      logic found, seen, rv_now, do_flush, do_stall;

      lat_min = 0;
      lat_max = 0;
      gnt_pct = 100;
      do_reset();
      boot_check();
      repeat (6) step(1'b0, 1'b0, '0);

      // Stall in steady state: outputs hold, credit stops requests.
      n_gr = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, '0);
         n_gr += int'(last_gnt);
      end
      check("stall_extra_grants_le2", 32'(n_gr <= 2), 32'd1);
      repeat (6) step(1'b0, 1'b0, '0);

      // Zero-wait flush: target requested at F+1, valid again at edge F+4.
      step(1'b0, 1'b1, 32'h0000_0181);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, '0);
         if (k == 0) begin
            check("flush_req", 32'(last_req), 32'd1);
            check("flush_req_addr", last_addr, 32'h0000_0180);
         end
         check("flush_gap_valid", 32'(is_valid_o), 32'(k == 2));
      end
      check("flush_target_pc", program_counter_o, 32'h0000_0184);

      // Flush with two responses in flight: both must be discarded.
      lat_min = 2;
      lat_max = 2;
      found   = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (pend.size() == 2 && pend[0].due > cyc) found = 1'b1;
         else step(1'b0, 1'b0, '0);
      end
      check("inflight2_setup", 32'(found), 32'd1);
      step(1'b0, 1'b1, 32'h0000_0200);
      check("drop_after_flush", 32'(dut.drop_q), 32'd2);
      lat_min = 0;
      lat_max = 0;
      seen    = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step(1'b0, 1'b0, '0);
         seen = is_valid_o;
      end
      check("flush2_valid_seen", 32'(seen), 32'd1);
      check("flush2_target_pc", program_counter_o, 32'h0000_0204);

      // Flush coincident with rvalid while stalled.
      lat_min = 2;
      lat_max = 2;
      found   = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (pend.size() >= 2 && pend[0].due <= cyc) found = 1'b1;
         else step(1'b0, 1'b0, '0);
      end
      check("coincident_setup", 32'(found), 32'd1);
      exp_drop = pend.size() - 1;
      step(1'b1, 1'b1, 32'h0000_0300);
      check("drop_coincident", 32'(dut.drop_q), 32'(exp_drop));
      check("coincident_valid_next", 32'(is_valid_o), 32'd0);
      lat_min = 0;
      lat_max = 0;
      seen    = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step(1'b0, 1'b0, '0);
         seen = is_valid_o;
      end
      check("flush3_valid_seen", 32'(seen), 32'd1);
      check("flush3_target_pc", program_counter_o, 32'h0000_0304);

      // Random latency, grant gaps, stalls and flushes.
      lat_min = 0;
      lat_max = 4;
      gnt_pct = 70;
      for (int i = 0; i < 400; i++) begin
         rv_now   = (pend.size() > 0) && (pend[0].due <= cyc);
         do_flush = ($urandom_range(99) < 3) && ((pend.size() - int'(rv_now)) <= FIFO_DEPTH);
         do_stall = ($urandom_range(99) < 15);
         step(do_stall, do_flush, WORD'($urandom_range(32'h0000_FFFF)));
      end

      // Asynchronous reset between edges, then a clean restart.
      lat_min = 0;
      lat_max = 0;
      gnt_pct = 100;
      repeat (8) step(1'b0, 1'b0, '0);
      #2;
      reset_i = 1'b1;
      #1;
      check("async_rst_req", 32'(imem_req_o), 32'd0);
      check("async_rst_valid", 32'(is_valid_o), 32'd0);
      check("async_rst_pc_out", program_counter_o, 32'd0);
      check("async_rst_instr", 32'(instruction_o), 32'd0);
      do_reset();
      boot_check();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
